// File: rtl/im_loader.sv
// Program loader: assembles a byte stream into 16-bit words, writes them into
// instruction memory and holds the CPU in reset until the image is complete.
module im_loader #(
  parameter int RST_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_req,
  input  logic [9:0]  word_count,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        im_en_write,
  output logic [9:0]  im_address,
  output logic [15:0] im_data,
  output logic        cpu_reset,
  output logic        cpu_start,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {IDLE, HI, LO, WRITE, RST, RUN} state_t;

  state_t      state;
  logic [9:0]  count_q;
  logic [9:0]  addr_q;
  logic [7:0]  hi_byte;
  logic [7:0]  lo_byte;
  logic [15:0] rst_cnt;

  logic xfer;
  logic last_word;

  assign xfer      = byte_valid & byte_ready;
  assign last_word = (addr_q == count_q - 10'd1);

  // Outputs are registered alongside the state: every transition below also
  // sets the output values that belong to the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: reset is synchronous, so it lives inside the clocked branch and
      // wins over every other action in the same cycle.
      state       <= IDLE;
      count_q     <= '0;
      addr_q      <= '0;
      hi_byte     <= '0;
      lo_byte     <= '0;
      rst_cnt     <= '0;
      byte_ready  <= 1'b0;
      im_en_write <= 1'b0;
      im_address  <= '0;
      im_data     <= '0;
      cpu_reset   <= 1'b1;
      cpu_start   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      // NOTE: the strobe defaults low each cycle so it is exactly one cycle wide.
      im_en_write <= 1'b0;
      unique case (state)
        IDLE, RUN: begin
          if (load_req) begin
            cpu_reset <= 1'b1;
            cpu_start <= 1'b0;
            done      <= 1'b0;
            if (word_count != 10'd0) begin
              state      <= HI;
              count_q    <= word_count;
              addr_q     <= '0;
              error      <= 1'b0;
              byte_ready <= 1'b1;
              busy       <= 1'b1;
            end else begin
              state <= IDLE;
              error <= 1'b1;
            end
          end
        end
        HI: begin
          if (xfer) begin
            hi_byte <= byte_data;
            state   <= LO;
          end
        end
        LO: begin
          if (xfer) begin
            lo_byte     <= byte_data;
            state       <= WRITE;
            byte_ready  <= 1'b0;
            im_en_write <= 1'b1;
            im_address  <= addr_q;
            im_data     <= {hi_byte, byte_data};
          end
        end
        WRITE: begin
          if (last_word) begin
            state   <= RST;
            rst_cnt <= 16'(RST_CYCLES);
          end else begin
            addr_q     <= addr_q + 10'd1;
            state      <= HI;
            byte_ready <= 1'b1;
          end
        end
        RST: begin
          // A count of 0 or 1 still gives one RST cycle before release.
          if (rst_cnt <= 16'd1) begin
            state     <= RUN;
            rst_cnt   <= '0;
            cpu_reset <= 1'b0;
            cpu_start <= 1'b1;
            done      <= 1'b1;
            busy      <= 1'b0;
          end else begin
            rst_cnt <= rst_cnt - 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_im_loader.sv
// Directed bench for im_loader: a cycle-by-cycle vector table for the basic,
// reload and zero-count flows, plus hand sequences for throttling and abort.
module tb_im_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_req;
  logic [9:0]  word_count;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        im_en_write;
  logic [9:0]  im_address;
  logic [15:0] im_data;
  logic        cpu_reset;
  logic        cpu_start;
  logic        busy;
  logic        done;
  logic        error;

  im_loader #(.RST_CYCLES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_req   (load_req),
    .word_count (word_count),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .im_en_write(im_en_write),
    .im_address (im_address),
    .im_data    (im_data),
    .cpu_reset  (cpu_reset),
    .cpu_start  (cpu_start),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        lr;
    logic [9:0]  wc;
    logic        bv;
    logic [7:0]  bd;
    logic [32:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [25:0] writes[$];
  int          n_vec = 0;
  int          n_bad = 0;

  logic [32:0] outs;
  assign outs = {byte_ready, im_en_write, im_address, im_data,
                 cpu_reset, cpu_start, busy, done, error};

  // Every write strobe is captured away from the active edge.
  always @(negedge clk) if (im_en_write) writes.push_back({im_address, im_data});

  function automatic logic [32:0] o(logic rdy, logic we, logic [9:0] a, logic [15:0] d,
                                    logic cr, logic cs, logic bz, logic dn, logic er);
    return {rdy, we, a, d, cr, cs, bz, dn, er};
  endfunction

  function automatic vec_t mk(logic rst, logic lr, logic [9:0] wc, logic bv,
                              logic [7:0] bd, logic [32:0] exp);
    vec_t v;
    v.rst = rst; v.lr = lr; v.wc = wc; v.bv = bv; v.bd = bd; v.exp = exp;
    return v;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(logic rst, logic lr, logic [9:0] wc, logic bv, logic [7:0] bd);
    reset = rst; load_req = lr; word_count = wc; byte_valid = bv; byte_data = bd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(string name, logic [7:0] b);
    for (int i = 0; i < 10 && !byte_ready; i++) tick();
    check({name, "_ready"}, 64'(byte_ready), 64'd1);
    drive(0, 0, 10'd0, 1, b);
    tick();
    drive(0, 0, 10'd0, 0, 8'h00);
  endtask

  localparam logic [32:0] R = 33'({1'b0, 1'b0, 10'd0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});

  initial begin
    logic [15:0] thr_words [2];
    thr_words[0] = 16'h4004;
    thr_words[1] = 16'h7000;
    drive(1, 0, 10'd0, 0, 8'h00);

    // Reset (with a competing load_req/byte), then idle with byte_valid high.
    vecs.push_back(mk(1, 0, 10'd0, 0, 8'h00, R));
    vecs.push_back(mk(1, 1, 10'd2, 1, 8'h11, R));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 0, 10'd0, 1, 8'hAA, R));
    // Basic 2-word load, bytes back-to-back.
    vecs.push_back(mk(0, 1, 10'd2, 0, 8'h00, o(1, 0, 10'd0, 16'h0000, 1, 0, 1, 0, 0)));
    vecs.push_back(mk(0, 0, 10'd0, 1, 8'h40, o(1, 0, 10'd0, 16'h0000, 1, 0, 1, 0, 0)));
    vecs.push_back(mk(0, 0, 10'd0, 1, 8'h04, o(0, 1, 10'd0, 16'h4004, 1, 0, 1, 0, 0)));
    vecs.push_back(mk(0, 0, 10'd0, 1, 8'h70, o(1, 0, 10'd0, 16'h4004, 1, 0, 1, 0, 0)));
    vecs.push_back(mk(0, 0, 10'd0, 1, 8'h70, o(1, 0, 10'd0, 16'h4004, 1, 0, 1, 0, 0)));
    vecs.push_back(mk(0, 0, 10'd0, 1, 8'h00, o(0, 1, 10'd1, 16'h7000, 1, 0, 1, 0, 0)));
    vecs.push_back(mk(0, 0, 10'd0, 0, 8'h00, o(0, 0, 10'd1, 16'h7000, 1, 0, 1, 0, 0)));
    vecs.push_back(mk(0, 0, 10'd0, 0, 8'h00, o(0, 0, 10'd1, 16'h7000, 1, 0, 1, 0, 0)));
    vecs.push_back(mk(0, 0, 10'd0, 0, 8'h00, o(0, 0, 10'd1, 16'h7000, 0, 1, 0, 1, 0)));
    vecs.push_back(mk(0, 0, 10'd0, 1, 8'h55, o(0, 0, 10'd1, 16'h7000, 0, 1, 0, 1, 0)));
    // Reload from RUN with 1 word; a load_req for 3 words in HI is ignored.
    vecs.push_back(mk(0, 1, 10'd1, 0, 8'h00, o(1, 0, 10'd1, 16'h7000, 1, 0, 1, 0, 0)));
    vecs.push_back(mk(0, 1, 10'd3, 1, 8'h12, o(1, 0, 10'd1, 16'h7000, 1, 0, 1, 0, 0)));
    vecs.push_back(mk(0, 0, 10'd0, 1, 8'h34, o(0, 1, 10'd0, 16'h1234, 1, 0, 1, 0, 0)));
    vecs.push_back(mk(0, 0, 10'd0, 0, 8'h00, o(0, 0, 10'd0, 16'h1234, 1, 0, 1, 0, 0)));
    vecs.push_back(mk(0, 0, 10'd0, 0, 8'h00, o(0, 0, 10'd0, 16'h1234, 1, 0, 1, 0, 0)));
    vecs.push_back(mk(0, 0, 10'd0, 0, 8'h00, o(0, 0, 10'd0, 16'h1234, 0, 1, 0, 1, 0)));
    // Zero count from IDLE sets a sticky error; a valid load clears it.
    vecs.push_back(mk(1, 0, 10'd0, 0, 8'h00, R));
    vecs.push_back(mk(0, 1, 10'd0, 0, 8'h00, o(0, 0, 10'd0, 16'h0000, 1, 0, 0, 0, 1)));
    vecs.push_back(mk(0, 0, 10'd0, 1, 8'hFF, o(0, 0, 10'd0, 16'h0000, 1, 0, 0, 0, 1)));
    vecs.push_back(mk(0, 1, 10'd1, 0, 8'h00, o(1, 0, 10'd0, 16'h0000, 1, 0, 1, 0, 0)));
    vecs.push_back(mk(0, 0, 10'd0, 1, 8'hFF, o(1, 0, 10'd0, 16'h0000, 1, 0, 1, 0, 0)));
    vecs.push_back(mk(0, 0, 10'd0, 1, 8'hFF, o(0, 1, 10'd0, 16'hFFFF, 1, 0, 1, 0, 0)));
    vecs.push_back(mk(0, 0, 10'd0, 0, 8'h00, o(0, 0, 10'd0, 16'hFFFF, 1, 0, 1, 0, 0)));
    vecs.push_back(mk(0, 0, 10'd0, 0, 8'h00, o(0, 0, 10'd0, 16'hFFFF, 1, 0, 1, 0, 0)));
    vecs.push_back(mk(0, 0, 10'd0, 0, 8'h00, o(0, 0, 10'd0, 16'hFFFF, 0, 1, 0, 1, 0)));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].lr, vecs[i].wc, vecs[i].bv, vecs[i].bd);
      tick();
      check($sformatf("vec%0d", i), 64'(outs), 64'(vecs[i].exp));
    end

    // Throttled stream: 3 idle cycles before every byte.
    drive(1, 0, 10'd0, 0, 8'h00);
    tick(); tick();
    drive(0, 1, 10'd2, 0, 8'h00);
    tick();
    drive(0, 0, 10'd0, 0, 8'h00);
    writes.delete();
    for (int w = 0; w < 2; w++) begin
      repeat (3) tick();
      send_byte("thr_hi", thr_words[w][15:8]);
      repeat (3) tick();
      check("thr_gap_writes", 64'(writes.size()), 64'(w));
      check("thr_gap_ready", 64'(byte_ready), 64'd1);
      send_byte("thr_lo", thr_words[w][7:0]);
    end
    for (int i = 0; i < 20 && !done; i++) tick();
    check("thr_run", 64'({cpu_reset, cpu_start, busy, done}), 64'(4'b0101));
    check("thr_count", 64'(writes.size()), 64'd2);
    check("thr_w0", 64'(writes[0]), 64'({10'd0, 16'h4004}));
    check("thr_w1", 64'(writes[1]), 64'({10'd1, 16'h7000}));

    // Abort: reset while waiting for the low byte of word 1 of a 3-word load.
    drive(1, 0, 10'd0, 0, 8'h00);
    tick(); tick();
    drive(0, 1, 10'd3, 0, 8'h00);
    tick();
    drive(0, 0, 10'd0, 0, 8'h00);
    writes.delete();
    send_byte("abt_b0", 8'hAA);
    send_byte("abt_b1", 8'hBB);
    send_byte("abt_b2", 8'hCC);
    drive(1, 0, 10'd0, 1, 8'hDD);
    tick();
    check("abt_reset_out", 64'(outs), 64'(R));
    drive(0, 0, 10'd0, 1, 8'hEE);
    repeat (5) tick();
    check("abt_idle_out", 64'(outs), 64'(R));
    check("abt_count", 64'(writes.size()), 64'd1);
    check("abt_w0", 64'(writes[0]), 64'({10'd0, 16'hAABB}));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/im_loader.md
IM_LOADER -- requirements
Module: im_loader

Interface
REQ-001 Parameter RST_CYCLES, default 2: number of cycles cpu_reset stays high after the last word is written.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 load_req  input  1  one-cycle request to start a program-load session.
REQ-005 word_count  input  10  number of 16-bit words to load; sampled only when load_req is accepted.
REQ-006 byte_valid  input  1  byte_data holds a valid byte.
REQ-007 byte_data  input  8  program byte stream, high byte of each word first.
REQ-008 byte_ready  output  1  loader can accept a byte this cycle.
REQ-009 im_en_write  output  1  instruction-memory write strobe.
REQ-010 im_address  output  10  instruction-memory write address.
REQ-011 im_data  output  16  instruction-memory write data.
REQ-012 cpu_reset  output  1  hold-reset to the processor.
REQ-013 cpu_start  output  1  start level to the control unit.
REQ-014 busy  output  1  a load session is in progress.
REQ-015 done  output  1  program loaded and CPU released.
REQ-016 error  output  1  sticky flag: last load_req had word_count == 0.

Function
REQ-017 States SHALL be IDLE, HI, LO, WRITE, RST and RUN, encoded in a registered state variable.
REQ-018 A byte transfer SHALL occur on any rising edge where byte_valid and byte_ready are both high; byte_ready SHALL be 1 only in HI and LO.
REQ-019 IDLE or RUN with load_req=1 and word_count != 0: latch word_count, clear the address counter to 0, clear error and done, and go to HI.
REQ-020 IDLE or RUN with load_req=1 and word_count == 0: set error=1, make no writes, and go to or stay in IDLE (RUN drops to IDLE).
REQ-021 load_req SHALL be ignored in HI, LO, WRITE and RST.
REQ-022 HI: on a transfer, byte_data is stored as the high byte and the state goes to LO; with no transfer, the state holds.
REQ-023 LO: on a transfer, byte_data is stored as the low byte and the state goes to WRITE; with no transfer, the state holds.
REQ-024 WRITE lasts exactly one cycle with im_en_write=1, im_address = the address counter, and im_data = {high byte, low byte}.
REQ-025 Leaving WRITE: if address == latched count - 1, go to RST and load the RST_CYCLES counter; otherwise increment the address and go to HI.
REQ-026 Minimum throughput SHALL be one word per 3 cycles.
REQ-027 im_en_write SHALL be 0 in every state except WRITE; im_address and im_data SHALL hold their last values outside WRITE.
REQ-028 RST: cpu_reset=1 for exactly RST_CYCLES cycles, then go to RUN.
REQ-029 RUN: cpu_reset=0, cpu_start=1 and done=1, held until reset or an accepted load_req.
REQ-030 cpu_reset SHALL be 1 in IDLE, HI, LO, WRITE and RST, so the CPU is held in reset while instruction memory is rewritten.
REQ-031 busy SHALL be 1 in HI, LO, WRITE and RST, and 0 otherwise.
REQ-032 An accepted load_req in RUN SHALL drive cpu_start=0 and cpu_reset=1 from the next cycle onward.
REQ-033 The address counter SHALL never exceed the latched count - 1; word_count = 1023 writes addresses 0..1022.

Reset
REQ-034 reset=1 SHALL force state=IDLE, address=0, both byte registers=0 and the RST counter=0.
REQ-035 During and after reset, outputs SHALL be: byte_ready=0, im_en_write=0, im_address=0, im_data=0, cpu_reset=1, cpu_start=0, busy=0, done=0, error=0.
REQ-036 reset SHALL take priority over load_req and byte transfers in the same cycle.
REQ-037 A reset mid-session SHALL abort the load with no further writes; a new load_req is then required.

Verification
REQ-038 Idle after reset: hold reset 2 cycles, then idle 5 cycles -> outputs remain at REQ-035 values; byte_valid=1 is not accepted.
REQ-039 Basic load: load_req with word_count=2, bytes 0x40,0x04,0x70,0x00 presented back-to-back -> writes 0x4004@0 then 0x7000@1, each a single-cycle strobe 3 cycles apart; cpu_reset high 2 cycles after the second write; then cpu_start=1, done=1, busy=0.
REQ-040 Throttled stream: same data with byte_valid low 3 cycles between bytes -> identical writes, with no progress during gaps.
REQ-041 Zero count: load_req with word_count=0 -> error=1, no im_en_write, state IDLE; a following load_req with word_count=1 and bytes 0xFF,0xFF -> error=0 and write 0xFFFF@0.
REQ-042 Abort: reset asserted in LO of word 1 of a 3-word load -> word 0 written, no further writes, outputs at REQ-035 values.
REQ-043 Reload and ignore: load_req in HI is ignored (count unchanged); load_req in RUN -> cpu_start=0 and cpu_reset=1 next cycle, and the reload restarts at address 0.
